// File: rtl/bpu_pkg.sv
// Shared definitions for the global-history branch predictor.
//   - Branch-type encodings as reported by the EX slots.
//   - 2-bit saturating counter encodings held in the PHT.
//   - Update-queue entry layout at the default table size.
package bpu_pkg;

    localparam int unsigned BPU_IDX_W      = 9;
    localparam int unsigned BPU_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        TYPE_NO     = 2'b00,
        TYPE_BRANCH = 2'b01,
        TYPE_RET    = 2'b10,
        TYPE_J      = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_ctr_e;

    typedef struct packed {
        logic [BPU_IDX_W-1:0] idx;
        logic                 taken;
    } upd_entry_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Update queue: two write ports, one read port, synchronous.
//   clk, rst         clock, synchronous active-high reset
//   flush            empties the queue at the next edge (contents discarded)
//   wr0_en/wr0_data  first (older) entry written this cycle
//   wr1_en/wr1_data  second (younger) entry; only valid together with wr0_en
//   rd_en            pop the head at the next edge (ignored when empty)
//   rd_data          head entry, combinational from the read pointer
//   count            occupancy
module bpu_upd_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr0_en,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [1:0]        n_wr;
    logic              pop;

    assign n_wr    = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign pop     = rd_en && (count != '0);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem[wptr] <= wr0_data;
        end
        if (wr1_en) begin
            mem[wptr + PTR_W'(1)] <= wr1_data;
        end
    end

    // Pointers wrap silently; occupancy is tracked separately in count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PTR_W'(n_wr);
            rptr  <= rptr + PTR_W'(pop);
            count <= count + CNT_W'(n_wr) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/bht_update_sched.sv
// Update-side controller for the GHR-XOR-PC indexed PHT.
// Owns the global history, accepts up to two resolved branches per cycle,
// queues their PHT updates and issues one PHT write per cycle. After reset
// or a software clear it sweeps every PHT entry to SNT/invalid.
//   clk, rst                     clock, synchronous active-high reset
//   ex1_* / ex2_*                resolved branches (slot 2 younger)
//   clr_req_i                    discard history and re-sweep the table
//   upd_ready_o                  EX may present branches this cycle
//   ghr_o                        global history for the predict side
//   pht_we_o/clr/idx/taken       PHT write port
//   init_busy_o                  sweep in progress
// Optional: define BPU_UPD_PERF_EN to add perf_upd_cnt_o / perf_stall_cnt_o.
module bht_update_sched
    import bpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = BPU_FIFO_DEPTH,
    parameter int unsigned IDX_W      = BPU_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ex1_type_i,
    input  logic             ex1_taken_i,
    input  logic [31:0]      ex1_pc_i,
    input  logic [1:0]       ex2_type_i,
    input  logic             ex2_taken_i,
    input  logic [31:0]      ex2_pc_i,
    input  logic             clr_req_i,
    output logic             upd_ready_o,
    output logic [IDX_W-1:0] ghr_o,
    output logic             pht_we_o,
    output logic             pht_clr_o,
    output logic [IDX_W-1:0] pht_idx_o,
    output logic             pht_taken_o,
    output logic             init_busy_o
`ifdef BPU_UPD_PERF_EN
   ,output logic [31:0]      perf_upd_cnt_o,
    output logic [31:0]      perf_stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e           state;
    logic [IDX_W-1:0] sweep_cnt;
    logic [IDX_W-1:0] ghr;

    logic [CNT_W-1:0] fifo_count;
    logic [IDX_W:0]   fifo_head;
    logic             fifo_flush;
    logic             pop;
    logic             wr0_en;
    logic             wr1_en;
    logic [IDX_W:0]   wr0_data;
    logic [IDX_W:0]   wr1_data;

    logic             in_run;
    logic             b1;
    logic             b2;
    logic             accept;
    logic [IDX_W-1:0] idx1;
    logic [IDX_W-1:0] idx2;
    logic [IDX_W-1:0] ghr_a;
    logic [IDX_W-1:0] ghr_b;

    assign in_run      = (state == S_RUN);
    assign upd_ready_o = in_run && (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
    assign accept      = upd_ready_o && !clr_req_i;
    assign fifo_flush  = in_run && clr_req_i;
    assign pop         = in_run && (fifo_count != '0);
    assign ghr_o       = ghr;
    assign init_busy_o = !in_run;

    assign b1 = (ex1_type_i == TYPE_BRANCH);
    assign b2 = (ex2_type_i == TYPE_BRANCH);

    // Slot 2 sees the history already shifted by slot 1 when slot 1 is a
    // branch. The queue is always written densely from port 0, so a lone
    // slot-2 branch goes through wr0.
    always_comb begin
        idx1     = ghr ^ ex1_pc_i[IDX_W+1:2];
        ghr_a    = b1 ? {ghr[IDX_W-2:0], ex1_taken_i} : ghr;
        idx2     = ghr_a ^ ex2_pc_i[IDX_W+1:2];
        ghr_b    = b2 ? {ghr_a[IDX_W-2:0], ex2_taken_i} : ghr_a;
        wr0_en   = accept && (b1 || b2);
        wr1_en   = accept && b1 && b2;
        wr0_data = b1 ? {idx1, ex1_taken_i} : {idx2, ex2_taken_i};
        wr1_data = {idx2, ex2_taken_i};
    end

    always_comb begin
        pht_we_o    = 1'b0;
        pht_clr_o   = 1'b0;
        pht_idx_o   = '0;
        pht_taken_o = 1'b0;
        if (!in_run) begin
            pht_we_o  = 1'b1;
            pht_clr_o = 1'b1;
            pht_idx_o = sweep_cnt;
        end else if (pop) begin
            pht_we_o    = 1'b1;
            pht_idx_o   = fifo_head[IDX_W:1];
            pht_taken_o = fifo_head[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            sweep_cnt <= '0;
            ghr       <= '0;
        end else begin
            unique case (state)
                S_INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (clr_req_i) begin
                        ghr       <= '0;
                        sweep_cnt <= '0;
                        state     <= S_INIT;
                    end else if (accept) begin
                        ghr <= ghr_b;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    bpu_upd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (IDX_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (pop),
        .rd_data  (fifo_head),
        .count    (fifo_count)
    );

`ifdef BPU_UPD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || clr_req_i) begin
            perf_upd_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (pop) begin
                perf_upd_cnt_o <= perf_upd_cnt_o + 32'd1;
            end
            if (in_run && !upd_ready_o && (b1 || b2)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bht_update_sched.sv
module tb_bht_update_sched;

    localparam int unsigned IDX_W = 9;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TBL   = 512;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       ex1_type = 2'b00;
    logic             ex1_taken = 1'b0;
    logic [31:0]      ex1_pc = '0;
    logic [1:0]       ex2_type = 2'b00;
    logic             ex2_taken = 1'b0;
    logic [31:0]      ex2_pc = '0;
    logic             clr_req = 1'b0;
    logic             upd_ready;
    logic [IDX_W-1:0] ghr;
    logic             pht_we;
    logic             pht_clr;
    logic [IDX_W-1:0] pht_idx;
    logic             pht_taken;
    logic             init_busy;

    always #5 clk = ~clk;

    bht_update_sched #(
        .FIFO_DEPTH (DEPTH),
        .IDX_W      (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex1_type_i  (ex1_type),
        .ex1_taken_i (ex1_taken),
        .ex1_pc_i    (ex1_pc),
        .ex2_type_i  (ex2_type),
        .ex2_taken_i (ex2_taken),
        .ex2_pc_i    (ex2_pc),
        .clr_req_i   (clr_req),
        .upd_ready_o (upd_ready),
        .ghr_o       (ghr),
        .pht_we_o    (pht_we),
        .pht_clr_o   (pht_clr),
        .pht_idx_o   (pht_idx),
        .pht_taken_o (pht_taken),
        .init_busy_o (init_busy)
    );

    // Expected update writes, {idx, taken}, in issue order.
    logic [IDX_W:0] exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [IDX_W-1:0] sweep_exp = '0;
    int             sweep_seen = 0;
    bit             mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every PHT write is either a sweep write (index order) or
    // must match the head of the expected-update queue.
    always @(negedge clk) begin
        if (mon_en && !rst && pht_we) begin
            if (pht_clr) begin
                chk("sweep_idx", 32'(pht_idx), 32'(sweep_exp));
                sweep_exp++;
                sweep_seen++;
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got idx 0x%0h taken %0b expected no write at %0t",
                         pht_idx, pht_taken, $time);
            end else begin
                logic [IDX_W:0] e;
                e = exp_q.pop_front();
                chk("upd_idx", 32'(pht_idx), 32'(e[IDX_W:1]));
                chk("upd_taken", 32'(pht_taken), 32'(e[0]));
            end
        end
    end

    task automatic clear_inputs();
        ex1_type = 2'b00; ex1_taken = 1'b0; ex1_pc = '0;
        ex2_type = 2'b00; ex2_taken = 1'b0; ex2_pc = '0;
    endtask

    // Present a pair, hold it until ready, return #1 after the accepting edge.
    task automatic issue(input logic [1:0] t1, input logic k1, input logic [31:0] p1,
                         input logic [1:0] t2, input logic k2, input logic [31:0] p2);
        int waited;
        ex1_type = t1; ex1_taken = k1; ex1_pc = p1;
        ex2_type = t2; ex2_taken = k2; ex2_pc = p2;
        waited = 0;
        while (!upd_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!upd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready 0 after %0d cycles expected 1", waited);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Entered #1 after the edge that put the design into INIT with index 0.
    task automatic sweep_phase(input string name);
        for (int i = 0; i < TBL; i++) begin
            if (i == 0 || i == TBL - 1) begin
                chk({name, "_busy"}, 32'(init_busy), 32'd1);
                chk({name, "_ready_low"}, 32'(upd_ready), 32'd0);
            end
            @(posedge clk); #1;
        end
        chk({name, "_ready_high"}, 32'(upd_ready), 32'd1);
        chk({name, "_busy_low"}, 32'(init_busy), 32'd0);
        chk({name, "_count"}, 32'(sweep_seen), TBL);
        chk({name, "_ghr"}, 32'(ghr), 32'd0);
        sweep_seen = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("rst_ready", 32'(upd_ready), 32'd0);
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_we", 32'(pht_we), 32'd1);
        chk("rst_clr", 32'(pht_clr), 32'd1);
        chk("rst_idx", 32'(pht_idx), 32'd0);
        chk("rst_taken", 32'(pht_taken), 32'd0);
        chk("rst_ghr", 32'(ghr), 32'd0);

        sweep_phase("init");

        // Single branch: idx = 0 ^ 0x004
        exp_q.push_back({9'h004, 1'b1});
        issue(2'b01, 1'b1, 32'h0000_0010, 2'b00, 1'b0, 32'h0);
        chk("ghr_single", 32'(ghr), 32'h001);

        // Two branches: idx1 = 1^2 = 3 (nt), GHR' = 2, idx2 = 2^3 = 1 (t)
        exp_q.push_back({9'h003, 1'b0});
        exp_q.push_back({9'h001, 1'b1});
        issue(2'b01, 1'b0, 32'h0000_0008, 2'b01, 1'b1, 32'h0000_000C);
        chk("ghr_pair", 32'(ghr), 32'h005);
        wait_drain("drain_pair");

        // Non-conditional types only
        issue(2'b10, 1'b1, 32'h0000_0040, 2'b11, 1'b1, 32'h0000_0080);
        @(posedge clk); #1;
        chk("ghr_nonbranch", 32'(ghr), 32'h005);
        chk("idle_we", 32'(pht_we), 32'd0);
        chk("idle_idx", 32'(pht_idx), 32'd0);
        chk("idle_taken", 32'(pht_taken), 32'd0);

        // Back-to-back pairs; pc bits [10:2] are zero so idx == history.
        exp_q.push_back({9'h005, 1'b1});
        exp_q.push_back({9'h00B, 1'b1});
        issue(2'b01, 1'b1, 32'h0000_1000, 2'b01, 1'b1, 32'h0000_1000);
        chk("ready_occ2", 32'(upd_ready), 32'd1);
        exp_q.push_back({9'h017, 1'b0});
        exp_q.push_back({9'h02E, 1'b1});
        issue(2'b01, 1'b0, 32'h0000_1000, 2'b01, 1'b1, 32'h0000_1000);
        chk("ready_occ3_a", 32'(upd_ready), 32'd0);
        exp_q.push_back({9'h05D, 1'b1});
        exp_q.push_back({9'h0BB, 1'b0});
        issue(2'b01, 1'b1, 32'h0000_1000, 2'b01, 1'b0, 32'h0000_1000);
        chk("ready_occ3_b", 32'(upd_ready), 32'd0);
        exp_q.push_back({9'h176, 1'b1});
        exp_q.push_back({9'h0ED, 1'b1});
        issue(2'b01, 1'b1, 32'h0000_1000, 2'b01, 1'b1, 32'h0000_1000);
        chk("ghr_burst", 32'(ghr), 32'h1DB);
        wait_drain("drain_burst");

        // Clear with three entries queued (X2, Y1, Y2)
        exp_q.push_back({9'h1DB, 1'b1});
        exp_q.push_back({9'h1B7, 1'b1});
        issue(2'b01, 1'b1, 32'h0000_1000, 2'b01, 1'b1, 32'h0000_1000);
        exp_q.push_back({9'h16F, 1'b0});
        exp_q.push_back({9'h0DE, 1'b0});
        issue(2'b01, 1'b0, 32'h0000_1000, 2'b01, 1'b0, 32'h0000_1000);
        chk("clr_queued", 32'(exp_q.size()), 32'd3);
        chk("clr_ready_low", 32'(upd_ready), 32'd0);
        clr_req  = 1'b1;
        ex1_type = 2'b01; ex1_taken = 1'b1; ex1_pc = 32'h0000_0004;
        @(posedge clk); #1;
        clr_req = 1'b0;
        clear_inputs();
        chk("clr_lost", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        sweep_exp  = '0;
        sweep_seen = 0;
        chk("clr_ghr", 32'(ghr), 32'd0);
        chk("clr_we", 32'(pht_we), 32'd1);
        chk("clr_clr", 32'(pht_clr), 32'd1);
        chk("clr_idx", 32'(pht_idx), 32'd0);
        sweep_phase("resweep");

        @(posedge clk); #1;
        chk("final_idle_we", 32'(pht_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bht_update_sched.md
Name: bht_update_sched

Overview:
- Update-side controller for the global-history branch predictor (GHR-XOR-PC indexed 512-entry 2-bit PHT).
- Owns the GHR and accepts up to two resolved branches per cycle from the dual EX slots.
- Computes each branch's PHT index, buffers updates in a small FIFO and issues one PHT write per cycle.
- Sequences a full-table initialisation sweep after reset and on software clear request.

Parameters:
- FIFO_DEPTH, 4, update queue entries; power of two, ≥2.
- IDX_W, 9, PHT index width and GHR width; table size = 2^IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex1_type_i  in  2  slot-1 branch type (00 none, 01 cond branch, 10 ret, 11 jump)
- ex1_taken_i  in  1  slot-1 resolved direction
- ex1_pc_i  in  32  slot-1 instruction address
- ex2_type_i, ex2_taken_i, ex2_pc_i  in  2/1/32  slot 2; program-order younger than slot 1
- clr_req_i  in  1  one-cycle pulse: discard history, re-sweep table
- upd_ready_o  out  1  EX may present branches this cycle
- ghr_o  out  IDX_W  current global history to predict side
- pht_we_o  out  1  PHT write strobe
- pht_clr_o  out  1  with pht_we_o: write entry to SNT and mark invalid
- pht_idx_o  out  IDX_W  PHT write index
- pht_taken_o  out  1  direction for saturating-counter update (ignored when pht_clr_o)
- init_busy_o  out  1  sweep in progress

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM→INIT, sweep_cnt=0, GHR=0, FIFO empty.
  - Outputs after that edge: upd_ready_o=0, init_busy_o=1, pht_we_o=1, pht_clr_o=1, pht_idx_o=0, pht_taken_o=0, ghr_o=0.
- INIT:
  - Each cycle drives pht_we_o=1, pht_clr_o=1, pht_idx_o=sweep_cnt, then sweep_cnt+1.
  - After index 2^IDX_W-1 is driven, next state RUN. Sweep takes exactly 512 cycles at default.
  - EX inputs are ignored; clr_req_i is ignored.
- RUN:
  - upd_ready_o = (free entries ≥ 2), evaluated combinationally from registered occupancy.
  - Inputs are sampled only when upd_ready_o=1. When upd_ready_o=0, EX holds its inputs; nothing is enqueued and GHR is unchanged.
- Enqueue (ready=1), only for type==01; other types are neither queued nor shift GHR:
  - Slot 1: idx1 = GHR ^ pc1[IDX_W+1:2]; GHR' = {GHR[IDX_W-2:0], taken1}.
  - Slot 2: idx2 uses GHR' if slot 1 was a branch, else GHR. GHR shifts again.
  - Both branches enqueue in order in the same cycle. Final GHR registered at that edge.
- Dequeue:
  - When RUN and FIFO non-empty: pht_we_o=1, pht_clr_o=0, pht_idx_o/pht_taken_o = head entry (combinational from head); pop at the edge.
  - One write per cycle.
  - Latency: branch accepted at edge N appears on pht_we_o in cycle N+1 when the queue was empty.
  - Simultaneous enqueue of 2 and pop of 1 is legal; occupancy is never exceeded because of the ready rule.
- Idle RUN: pht_we_o=0, pht_idx_o=0, pht_taken_o=0.
- clr_req_i in RUN: at the next edge, FIFO flushed (pending updates lost), GHR=0, sweep_cnt=0, →INIT. Same-cycle EX inputs are discarded.
- rst mid-INIT or mid-RUN: full restart of the sweep from 0.
- Pointer wrap: log2(FIFO_DEPTH)-bit pointers plus separate count; wrap-around silent.

Optional Feature:
- BPU_UPD_PERF_EN defined: adds outputs perf_upd_cnt_o[31:0] and perf_stall_cnt_o[31:0].
  - perf_upd_cnt_o: PHT update writes issued in RUN.
  - perf_stall_cnt_o: RUN cycles with upd_ready_o=0 while any ex*_type_i==01.
  - Both counters reset to 0 on rst or clr_req_i and wrap at 2^32.
- Not defined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package bpu_pkg:
  - Branch-type constants TYPE_NO/BRANCH/RET/J (00/01/10/11).
  - Counter encodings SNT/WNT/WT/ST.
  - Update-entry typedef {idx[IDX_W-1:0], taken}.
- One sub-module: bpu_upd_fifo (2-write/1-read synchronous FIFO with count output).
- FSM, GHR and index logic stay in the top.

Test Plan:
- Reset then idle → init_busy_o=1 for 512 cycles, pht_clr_o writes idx 0..511 in order, upd_ready_o rises in cycle 513, ghr_o=0.
- RUN, GHR=0, slot1 branch pc=0x0000_0010 taken, slot2 none → next cycle pht_we_o=1, idx=0x004, taken=1; ghr_o=0x001.
- GHR=0x001, slot1 branch pc=0x8 not-taken, slot2 branch pc=0xC taken → writes idx 0x003 (taken 0) then idx 0x00E^... i.e. GHR'=0x002 ^ 0x003 = 0x001 (taken 1) in consecutive cycles; final GHR=0x005.
- Slot types 10/11 only → no write, GHR unchanged.
- Two-branch bursts every cycle → FIFO fills, upd_ready_o=0 at occupancy 3 and 4; held inputs accepted once free ≥2; no entry lost or reordered.
- clr_req_i with 3 queued entries → no further update writes, GHR=0, 512-cycle sweep restarts from idx 0.
